// File: rtl/ulpi_link_pkg.sv
// Shared encodings for the link-side ULPI adapter: FSM states, command prefixes,
// RX CMD field layout and the Function Control register image.
package ulpi_link_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_TX_CMD   = 4'd1;
  localparam logic [3:0] ST_TX_DATA  = 4'd2;
  localparam logic [3:0] ST_TX_STP   = 4'd3;
  localparam logic [3:0] ST_REG_CMD  = 4'd4;
  localparam logic [3:0] ST_REG_DATA = 4'd5;
  localparam logic [3:0] ST_REG_STP  = 4'd6;
  localparam logic [3:0] ST_RX_TURN  = 4'd7;
  localparam logic [3:0] ST_RX       = 4'd8;
  localparam logic [3:0] ST_RX_EXIT  = 4'd9;

  localparam logic [1:0] TXCMD_PFX = 2'b01;
  localparam logic [1:0] REGW_PFX  = 2'b10;

  localparam int RXCMD_LS_LSB   = 0;
  localparam int RXCMD_VBUS_LSB = 2;
  localparam int RXCMD_EVT_LSB  = 4;

  localparam logic [1:0] RXEVT_INACTIVE = 2'b00;
  localparam logic [1:0] RXEVT_ACTIVE   = 2'b01;
  localparam logic [1:0] RXEVT_HOSTDISC = 2'b10;
  localparam logic [1:0] RXEVT_ERROR    = 2'b11;

  localparam int FC_XCVR_LSB   = 0;
  localparam int FC_TERM       = 2;
  localparam int FC_OPMODE_LSB = 3;
  localparam int FC_RESET      = 5;
  localparam int FC_SUSPENDM   = 6;

  // PHY reset bit is never requested from here; it stays 0 in every write.
  function automatic logic [7:0] fctrl_byte(input logic       suspendm,
                                            input logic [1:0] op_mode,
                                            input logic       term,
                                            input logic [1:0] xcvr);
    logic [7:0] b;
    b = 8'h00;
    b[FC_XCVR_LSB +: 2]   = xcvr;
    b[FC_TERM]            = term;
    b[FC_OPMODE_LSB +: 2] = op_mode;
    b[FC_RESET]           = 1'b0;
    b[FC_SUSPENDM]        = suspendm;
    return b;
  endfunction

endpackage

// File: rtl/ulpi_link_adapter_rxcmd_decode.sv
// Registered demux of PHY-driven bus cycles: nxt=1 bytes are RX data,
// nxt=0 bytes are RX CMDs that update linestate / rxactive / rxerror.
module ulpi_rxcmd_decode
  import ulpi_link_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_turn,
  input  logic       in_rx,
  input  logic       in_exit,
  input  logic       tx_abort,
  input  logic       dir,
  input  logic       nxt,
  input  logic [7:0] bus,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error,
  output logic [1:0] line_state
);

  logic [1:0] evt;
  assign evt = bus[RXCMD_EVT_LSB +: 2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_active  <= 1'b0;
      rx_error   <= 1'b0;
      line_state <= 2'b00;
    end else begin
      rx_valid <= 1'b0;
      if (in_turn) begin
        if (nxt) rx_active <= 1'b1;
      end else if (in_rx && dir) begin
        if (nxt) begin
          rx_data  <= bus;
          rx_valid <= 1'b1;
        end else begin
          line_state <= bus[RXCMD_LS_LSB +: 2];
          rx_active  <= (evt == RXEVT_ACTIVE) || (evt == RXEVT_ERROR);
          rx_error   <= (evt == RXEVT_ERROR);
        end
      end else if (in_exit) begin
        // linestate deliberately survives the exit turnaround
        rx_active <= 1'b0;
        rx_error  <= 1'b0;
      end else if (tx_abort) begin
        rx_error <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ulpi_link_adapter.sv
// Link-side ULPI controller: UTMI TX -> TXCMD/data/stp, PHY bus cycles -> UTMI RX,
// and Function Control register writes whenever opmode/xcvr/term change.
module ulpi_link_adapter
  import ulpi_link_pkg::*;
#(
  parameter logic [5:0] FCTRL_ADDR = 6'h04,
  parameter logic       SUSPENDM   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o,
  input  logic [7:0] utmi_data_out_i,
  input  logic       utmi_txvalid_i,
  output logic       utmi_txready_o,
  output logic [7:0] utmi_data_in_o,
  output logic       utmi_rxvalid_o,
  output logic       utmi_rxactive_o,
  output logic       utmi_rxerror_o,
  output logic [1:0] utmi_linestate_o,
  input  logic [1:0] utmi_op_mode_i,
  input  logic [1:0] utmi_xcvrselect_i,
  input  logic       utmi_termselect_i
);

  logic [3:0] st, st_nxt;
  logic [7:0] data_q, data_nxt;
  logic       stp_q;
  logic       fctrl_dirty;
  logic [4:0] fc_q, fc_in;
  logic       reg_data_entry;

  assign fc_in          = {utmi_op_mode_i, utmi_termselect_i, utmi_xcvrselect_i};
  assign reg_data_entry = (st == ST_REG_CMD) && ulpi_nxt_i && !ulpi_dir_i;

  // dir always wins: any command not yet accepted by nxt is abandoned.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:     if (ulpi_dir_i)          st_nxt = ST_RX_TURN;
                   else if (utmi_txvalid_i) st_nxt = ST_TX_CMD;
                   else if (fctrl_dirty)    st_nxt = ST_REG_CMD;
      ST_TX_CMD:   if (ulpi_dir_i)          st_nxt = ST_RX_TURN;
                   else if (ulpi_nxt_i)     st_nxt = ST_TX_DATA;
      ST_TX_DATA:  if (ulpi_dir_i)          st_nxt = ST_RX_TURN;
                   else if (!utmi_txvalid_i) st_nxt = ST_TX_STP;
      ST_REG_CMD:  if (ulpi_dir_i)          st_nxt = ST_RX_TURN;
                   else if (ulpi_nxt_i)     st_nxt = ST_REG_DATA;
      ST_REG_DATA: if (ulpi_dir_i)          st_nxt = ST_RX_TURN;
                   else if (ulpi_nxt_i)     st_nxt = ST_REG_STP;
      ST_RX_TURN:  st_nxt = ST_RX;
      ST_RX:       if (!ulpi_dir_i)         st_nxt = ST_RX_EXIT;
      ST_TX_STP, ST_REG_STP, ST_RX_EXIT:
                   st_nxt = ulpi_dir_i ? ST_RX_TURN : ST_IDLE;
      default:     st_nxt = ST_IDLE;
    endcase
  end

  // Bus byte is registered off the next state; the register payload is
  // frozen while REG_DATA waits for nxt.
  always_comb begin
    data_nxt = 8'h00;
    case (st_nxt)
      ST_TX_CMD:   data_nxt = {TXCMD_PFX, 2'b00, utmi_data_out_i[3:0]};
      ST_REG_CMD:  data_nxt = {REGW_PFX, FCTRL_ADDR};
      ST_REG_DATA: data_nxt = (st == ST_REG_DATA) ? data_q :
                              fctrl_byte(SUSPENDM, utmi_op_mode_i,
                                         utmi_termselect_i, utmi_xcvrselect_i);
      default:     data_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st          <= ST_IDLE;
      data_q      <= 8'h00;
      stp_q       <= 1'b0;
      fctrl_dirty <= 1'b1;
      fc_q        <= 5'b0;
    end else begin
      st     <= st_nxt;
      data_q <= data_nxt;
      stp_q  <= (st_nxt == ST_TX_STP) || (st_nxt == ST_REG_STP);
      if (reg_data_entry) fc_q <= fc_in;
      if (st == ST_REG_STP)   fctrl_dirty <= (fc_in != fc_q);
      else if (fc_in != fc_q) fctrl_dirty <= 1'b1;
    end
  end

  assign ulpi_data_o    = (st == ST_TX_DATA) ? utmi_data_out_i : data_q;
  assign ulpi_stp_o     = stp_q;
  assign utmi_txready_o = ((st == ST_TX_CMD) || (st == ST_TX_DATA)) &&
                          ulpi_nxt_i && !ulpi_dir_i && utmi_txvalid_i;

  ulpi_rxcmd_decode u_rx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_turn    (st == ST_RX_TURN),
    .in_rx      (st == ST_RX),
    .in_exit    (st == ST_RX_EXIT),
    .tx_abort   ((st == ST_TX_DATA) && ulpi_dir_i),
    .dir        (ulpi_dir_i),
    .nxt        (ulpi_nxt_i),
    .bus        (ulpi_data_i),
    .rx_data    (utmi_data_in_o),
    .rx_valid   (utmi_rxvalid_o),
    .rx_active  (utmi_rxactive_o),
    .rx_error   (utmi_rxerror_o),
    .line_state (utmi_linestate_o)
  );

endmodule

// File: doc/ulpi_link_adapter.md
Name: ulpi_link_adapter

Overview:
- Link-side ULPI controller: the other end of the soft PHY's ULPI interface.
- Presents a UTMI-style port to the USB device controller.
- Converts UTMI transmit packets into ULPI TXCMD/data/stp sequences.
- Decodes PHY-driven bus cycles (RX CMD and RX data) back into UTMI receive signals, and mirrors opmode/xcvrselect/termselect into the PHY Function Control register using ULPI register writes.

Parameters:
- FCTRL_ADDR, 6'h04, ULPI register address of Function Control.
- SUSPENDM, 1'b1, value written to Function Control bit 6.

Ports:
- clk_i  in  1  60 MHz ULPI clock; all logic is in this domain.
- rst_i  in  1  synchronous reset, active-high.
- ulpi_data_i  in  8  bus byte driven by the PHY (PHY ulpi_rxdata_o).
- ulpi_data_o  out  8  bus byte driven by the link (PHY ulpi_txdata_i).
- ulpi_dir_i  in  1  bus direction; 1 = PHY drives the bus.
- ulpi_nxt_i  in  1  PHY next/throttle.
- ulpi_stp_o  out  1  link stop.
- utmi_data_out_i  in  8  TX byte; the first byte of a packet is the PID.
- utmi_txvalid_i  in  1  TX packet in progress.
- utmi_txready_o  out  1  current TX byte consumed this cycle.
- utmi_data_in_o  out  8  RX byte.
- utmi_rxvalid_o  out  1  utmi_data_in_o valid (1-cycle pulse per byte).
- utmi_rxactive_o  out  1  receive packet active.
- utmi_rxerror_o  out  1  receive error.
- utmi_linestate_o  out  2  line state decoded from RX CMD.
- utmi_op_mode_i  in  2  requested OpMode.
- utmi_xcvrselect_i  in  2  requested XcvrSelect.
- utmi_termselect_i  in  1  requested TermSelect.

Behaviour:
- Reset values:
  - All outputs are 0, including ulpi_data_o = 8'h00 and ulpi_stp_o = 0.
  - fctrl_dirty = 1: one Function Control write is always issued after reset.
- State machine: IDLE, TX_CMD, TX_DATA, TX_STP, REG_CMD, REG_DATA, REG_STP, RX_TURN, RX, RX_EXIT.
- Turnaround:
  - The first cycle after any dir edge is a turnaround cycle.
  - ulpi_data_i is ignored in that cycle.
  - The link does not drive meaningful data in that cycle (ulpi_data_o = 0).
- IDLE:
  - dir = 1 -> RX_TURN. This has highest priority.
  - Otherwise utmi_txvalid_i = 1 -> TX_CMD.
  - Otherwise fctrl_dirty = 1 -> REG_CMD.
  - In IDLE, ulpi_data_o = 8'h00.
- TX_CMD:
  - ulpi_data_o = {4'b0100, utmi_data_out_i[3:0]} (registered).
  - On nxt = 1 with dir = 0: utmi_txready_o = 1 (PID consumed), go to TX_DATA.
- TX_DATA:
  - ulpi_data_o = utmi_data_out_i, passed combinationally (the only combinational data path).
  - utmi_txready_o = ulpi_nxt_i & ~ulpi_dir_i.
  - utmi_txvalid_i = 0 -> TX_STP.
- TX_STP:
  - One cycle with ulpi_stp_o = 1 and ulpi_data_o = 8'h00, then IDLE.
  - A zero-length packet (PID only) therefore gives TXCMD, then stp.
- Abort: dir = 1 in TX_CMD or REG_CMD before nxt:
  - Abandon the command, go to RX_TURN, and utmi_txready_o stays 0.
  - A TX is re-issued from IDLE while txvalid is still high; REGW is retried because fctrl_dirty is still set.
  - dir = 1 in TX_DATA drives utmi_rxerror_o = 0 and goes to RX_TURN. The controller sees txready stop; the packet is lost and the controller retries.
- Register write:
  - REG_CMD drives {2'b10, FCTRL_ADDR}; on nxt -> REG_DATA.
  - REG_DATA drives {1'b0, SUSPENDM, 1'b0, op_mode, termselect, xcvrselect}; on nxt -> REG_STP.
  - REG_STP: stp = 1 for one cycle, clear fctrl_dirty, then IDLE.
- fctrl_dirty:
  - Set whenever the registered copy of {op_mode, termselect, xcvrselect} differs from the inputs.
  - The value sent is the value sampled at REG_DATA.
  - If the inputs change during REG_*, the flag re-sets after REG_STP.
- RX_TURN:
  - nxt = 1 sets utmi_rxactive_o = 1 (RX start from idle).
  - Then go to RX.
- RX (dir = 1):
  - nxt = 1: the byte is RX data. utmi_data_in_o <= byte, utmi_rxvalid_o <= 1 (1-cycle latency).
  - nxt = 0: the byte is an RX CMD.
    - linestate <= byte[1:0].
    - rxactive <= byte[4].
    - rxerror <= (byte[5:4] == 2'b11).
  - dir = 0 -> RX_EXIT.
- RX_EXIT (turnaround):
  - rxactive <= 0, rxvalid <= 0, rxerror <= 0; then IDLE.
  - linestate holds its last value.
- Reset mid-operation: rst_i forces IDLE and all outputs to their reset values on the next edge, regardless of state.

Decomposition:
- Package ulpi_link_pkg holds:
  - state enum;
  - TXCMD prefix 2'b01 and REGW prefix 2'b10;
  - RX CMD field positions (LINESTATE 1:0, VBUS 3:2, RXEVENT 5:4) and RXEVENT encodings;
  - Function Control bit positions.
- One natural sub-module is ulpi_rxcmd_decode: registered RX CMD/data demux that produces the UTMI receive outputs.

Test Plan:
- TX packet: drive PID 8'hC3, then 8'h11, 8'h22, with nxt high one cycle after TXCMD -> ulpi_data_o shows 8'h43, 8'h11, 8'h22, then stp = 1 with data 8'h00, and exactly 3 txready pulses.
- RX packet: dir rises with nxt = 1, then 4 cycles of nxt = 1 carrying 8'hA5, 8'h01, 8'h02, 8'h03, then dir falls -> rxactive high from the cycle after the turnaround, 4 rxvalid pulses with matching bytes, rxactive low after RX_EXIT.
- RX CMD: dir = 1, nxt = 0, byte 8'h31 -> linestate = 2'b01, rxactive = 1, rxerror = 1; then byte 8'h02 -> linestate = 2'b10, rxactive = 0, rxerror = 0.
- Function Control: after reset, and again after op_mode changes to 2'b10 -> REGW 8'h84 followed by data 8'h48 (op_mode = 2'b01, xcvr/term = 0) and then 8'h50 (op_mode = 2'b10), each followed by stp.
- Abort: dir = 1 asserted while in TX_CMD before nxt -> no txready, RX handled, and TXCMD re-issued once dir falls.
- Reset during TX_DATA -> next cycle ulpi_data_o = 0, stp = 0, txready = 0, and a REGW is issued afterward.
